// File: rtl/johnson_counter_4bit.sv
// 4-stage Johnson (twisted-ring) counter with state decode, terminal count and legality flag.
// Optional build macro JOHNSON_SELF_CORRECT_EN: illegal states reload 0000 on the next edge.
module johnson_counter_4bit (
  input  logic       CLK1,
  input  logic       reset,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       Q4,
  output logic [2:0] state_idx,
  output logic       tc,
  output logic       valid
);

  // ring_q packs {Q1,Q2,Q3,Q4}; bit 3 is the ring input stage, bit 0 the ring output stage.
  logic [3:0] ring_q, ring_d;

  always_comb begin
    state_idx = 3'd0;
    valid     = 1'b1;
    unique case (ring_q)
      4'b0000: state_idx = 3'd0;
      4'b1000: state_idx = 3'd1;
      4'b1100: state_idx = 3'd2;
      4'b1110: state_idx = 3'd3;
      4'b1111: state_idx = 3'd4;
      4'b0111: state_idx = 3'd5;
      4'b0011: state_idx = 3'd6;
      4'b0001: state_idx = 3'd7;
      default: valid     = 1'b0;
    endcase
  end

  assign tc = (ring_q == 4'b0001);

  always_comb begin
    ring_d = {~ring_q[0], ring_q[3:1]};
`ifdef JOHNSON_SELF_CORRECT_EN
    if (!valid) ring_d = 4'b0000;
`endif
  end

  always_ff @(posedge CLK1) begin
    if (reset) ring_q <= 4'b0000;
    else       ring_q <= ring_d;
  end

  assign Q1 = ring_q[3];
  assign Q2 = ring_q[2];
  assign Q3 = ring_q[1];
  assign Q4 = ring_q[0];

endmodule

// File: tb/tb_johnson_counter_4bit.sv
// Directed bench for johnson_counter_4bit; expected values are hand-computed constants.
`timescale 1ns/100ps
module tb_johnson_counter_4bit;

  logic       CLK1 = 1'b0;
  logic       reset;
  logic       Q1, Q2, Q3, Q4;
  logic [2:0] state_idx;
  logic       tc, valid;
  logic [3:0] q;

  int total = 0;
  int bad   = 0;

  johnson_counter_4bit dut (
    .CLK1(CLK1), .reset(reset),
    .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4),
    .state_idx(state_idx), .tc(tc), .valid(valid)
  );

  always #1 CLK1 = ~CLK1;
  assign q = {Q1, Q2, Q3, Q4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] seq [8];
  logic [3:0] ill [6];
  int tc_cnt, tc_first, tc_last;

  initial begin
    seq[0] = 4'b1000; seq[1] = 4'b1100; seq[2] = 4'b1110; seq[3] = 4'b1111;
    seq[4] = 4'b0111; seq[5] = 4'b0011; seq[6] = 4'b0001; seq[7] = 4'b0000;
    ill[0] = 4'b0100; ill[1] = 4'b1010; ill[2] = 4'b0110;
    ill[3] = 4'b1101; ill[4] = 4'b1001; ill[5] = 4'b0010;

    // reset hold
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK1);
      chk("rst_q", q, 4'b0000);
      chk("rst_idx", state_idx, 3'd0);
      chk("rst_valid", valid, 1'b1);
      chk("rst_tc", tc, 1'b0);
    end

    // sequence after release
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK1);
      chk($sformatf("seq_q%0d", i), q, seq[i]);
      chk($sformatf("seq_idx%0d", i), state_idx, (i + 1) % 8);
      chk($sformatf("seq_tc%0d", i), tc, (i == 6));
      chk($sformatf("seq_valid%0d", i), valid, 1'b1);
    end

    // wrap and terminal count over 24 edges
    tc_cnt = 0; tc_first = -1; tc_last = -1;
    for (int e = 1; e <= 24; e++) begin
      @(negedge CLK1);
      if (tc === 1'b1) begin
        tc_cnt++;
        if (tc_first < 0) tc_first = e;
        tc_last = e;
        chk("tc_on_0001", q, 4'b0001);
      end
      if (e % 8 == 0) chk($sformatf("wrap_q%0d", e), q, 4'b0000);
    end
    chk("tc_cnt", tc_cnt, 3);
    chk("tc_first", tc_first, 7);
    chk("tc_last", tc_last, 23);

    // mid-sequence reset from 1110
    repeat (3) @(negedge CLK1);
    chk("mid_pre", q, 4'b1110);
    reset = 1'b1;
    @(negedge CLK1);
    chk("mid_rst", q, 4'b0000);
    reset = 1'b0;
    @(negedge CLK1);
    chk("mid_rel", q, 4'b1000);

    // illegal pattern decode
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK1);
      force dut.ring_q = ill[i];
      #0.2;
      chk($sformatf("ill_valid%0d", i), valid, 1'b0);
      chk($sformatf("ill_idx%0d", i), state_idx, 3'd0);
      chk($sformatf("ill_tc%0d", i), tc, 1'b0);
      release dut.ring_q;
    end

    // illegal state evolution from 0100
    @(negedge CLK1);
    force dut.ring_q = 4'b0100;
    #0.2;
    release dut.ring_q;
    @(negedge CLK1);
`ifdef JOHNSON_SELF_CORRECT_EN
    chk("fix_q", q, 4'b0000);
    chk("fix_valid", valid, 1'b1);
    @(negedge CLK1);
    chk("fix_next", q, 4'b1000);
    chk("fix_idx", state_idx, 3'd1);
`else
    chk("loop_q1", q, 4'b1010);
    chk("loop_valid1", valid, 1'b0);
    chk("loop_idx1", state_idx, 3'd0);
    @(negedge CLK1);
    chk("loop_q2", q, 4'b1101);
    chk("loop_valid2", valid, 1'b0);
    chk("loop_idx2", state_idx, 3'd0);
    reset = 1'b1;
    @(negedge CLK1);
    chk("loop_rst_q", q, 4'b0000);
    chk("loop_rst_valid", valid, 1'b1);
    reset = 1'b0;
    @(negedge CLK1);
    chk("loop_rel", q, 4'b1000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/johnson_counter_4bit.md
Name:
johnson_counter_4bit

Overview:
- 4-bit Johnson (twisted-ring) counter: 8 legal states, one bit changes per clock.
- Used as a divide-by-8 sequencer / glitch-free phase generator.
- Outputs:
  - raw ring bits Q1..Q4
  - decoded state index
  - terminal-count flag
  - legality flag
- Only inputs are clock and reset, so the block free-runs whenever reset is low.

Parameters:
- None. Width fixed at 4 stages; reset state fixed at Q1..Q4 = 0000.

Ports:
- CLK1  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Q1  output  1  stage 1 (ring input stage), registered
- Q2  output  1  stage 2, registered
- Q3  output  1  stage 3, registered
- Q4  output  1  stage 4 (ring output stage), registered
- state_idx  output  3  decoded position in sequence 0..7 (combinational from Q1..Q4)
- tc  output  1  terminal count; high while in state index 7 (combinational)
- valid  output  1  high while Q1..Q4 is one of the 8 legal states (combinational)

Behaviour:
- All registers update only on rising CLK1. No asynchronous paths.
- Reset:
  - reset=1 at a rising edge loads Q1..Q4 = 0000.
  - Reset has priority over counting and takes effect mid-sequence from any state, legal or illegal.
  - While held, outputs stay 0000, state_idx=0, tc=0, valid=1.
- Count (reset=0), every rising edge:
  - Q1 <= ~Q4, Q2 <= Q1, Q3 <= Q2, Q4 <= Q3.
- Legal sequence (Q1Q2Q3Q4 -> state_idx):
  - 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7.
  - Wraps from 0001 back to 0000; period 8 clocks.
- First count edge after reset release gives 1000.
  - No extra latency: the edge where reset is sampled low advances the state.
- tc:
  - Equals 1 only when Q1..Q4 = 0001.
  - Asserted for exactly 1 cycle in every 8.
  - The next edge returns the counter to 0000.
- valid:
  - 1 for the 8 legal patterns, 0 for the other 8 (e.g. 0100, 1010, 0110, 1101).
- state_idx for illegal patterns is forced to 0. tc is 0 in illegal patterns.
- Outputs Q1..Q4 come directly from flops (glitch-free). Decoded outputs are pure combinational functions of those flops.
- Power-up state before first reset is undefined; the system must apply reset.

Optional Feature:
- Macro: JOHNSON_SELF_CORRECT_EN
- Defined:
  - On a rising edge with reset=0 and valid=0, next state is forced to 0000 instead of the shift.
  - Any illegal state therefore recovers to the legal ring within 1 clock, followed by the normal sequence.
- Not defined:
  - Plain shift rule applies in all states.
  - Illegal states circulate in their own 8-state illegal loop indefinitely.
  - valid stays 0 until reset.
- Legal-state behaviour is identical in both builds.

Test Plan:
- Reset hold:
  - CLK1 period 2 ns, reset=1 for 10 edges -> Q1..Q4=0000 every cycle, state_idx=0, valid=1, tc=0.
- Sequence after release:
  - Drop reset, clock 8 edges -> 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
  - state_idx steps 1..7 then 0.
- Wrap / tc:
  - Run 24 edges -> tc high exactly 3 times, each on 0001, each 8 edges apart.
  - Q1..Q4 = 0000 after edges 8, 16, 24.
- Mid-sequence reset:
  - From state 1110, assert reset for 1 edge -> 0000 on that edge.
  - Release -> next edge gives 1000.
- Illegal state, macro off:
  - Force flops to 0100, reset=0, clock 1 edge -> 1010.
  - valid=0 and state_idx=0 throughout.
  - Assert reset -> 0000, valid=1.
- Illegal state, JOHNSON_SELF_CORRECT_EN defined:
  - Force flops to 0100, clock 1 edge -> 0000, valid=1.
  - Next edge -> 1000.
